codec_reg_arbiter: RTL and testbench

- Shares the single CODEC register-access port of the codec controller between NUM_REQ independent requesters, e.g. the AXI register bank, a volume/mute sequencer and a diagnostics reader.
- Arbitration is round-robin. Exactly one register transaction is outstanding at a time.
- The block issues the rd/wr pulse, tracks controller_busy through to completion, captures read data, and returns a per-requester response with error status, including timeout recovery.
- Sits directly between the requesters and the controller's codec_rd_en / codec_wr_en / codec_reg_addr / codec_data_in / codec_data_out / controller_busy port.

---
 rtl/codec_arb_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/codec_reg_arbiter.sv | 116 +++++++++++
 tb/tb_codec_reg_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/codec_arb_pkg.sv
// codec_arb_pkg: shared types and widths for the CODEC register-port arbiter.
// Contents: state_t (arbiter FSM states), CODEC_AW (register address width),
// CODEC_DW (register data width).
package codec_arb_pkg;
   localparam int CODEC_AW = 8;
   localparam int CODEC_DW = 9;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after i_ptr.
// Ports: i_req  - request vector
//        i_ptr  - index of the last winner; search starts at i_ptr+1 and wraps
//        o_grant - one-hot grant (0 when no request)
//        o_idx  - binary index of the winner (0 when no request)
//        o_any  - at least one request is pending
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_idx,
   output logic         o_any
);
   // Walk from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      o_idx = '0;
      for (int k = N; k >= 1; k--)
         if (i_req[(int'(i_ptr) + k) % N]) o_idx = W'((int'(i_ptr) + k) % N);
   end
   assign o_any   = |i_req;
   assign o_grant = o_any ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/codec_reg_arbiter.sv
// codec_reg_arbiter: round-robin sharing of the codec controller register port.
// Ports: clk, reset (sync, active high)
//        req_valid/req_write/req_addr/req_wdata - packed per-requester requests
//        req_ack   - one-cycle grant pulse, request fields latched that cycle
//        rsp_valid/rsp_rdata/rsp_error - completion to the granted requester
//        arb_busy  - a transaction is in flight
//        codec_rd_en/codec_wr_en/codec_reg_addr/codec_data_in - controller command
//        codec_data_out/codec_data_out_valid/controller_busy/missed_ack - controller status
module codec_reg_arbiter
   import codec_arb_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [CODEC_AW*NUM_REQ-1:0]  req_addr,
   input  logic [CODEC_DW*NUM_REQ-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]           req_ack,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [CODEC_DW-1:0]          rsp_rdata,
   output logic                         rsp_error,
   output logic                         arb_busy,
   output logic                         codec_rd_en,
   output logic                         codec_wr_en,
   output logic [CODEC_AW-1:0]          codec_reg_addr,
   output logic [CODEC_DW-1:0]          codec_data_in,
   input  logic [CODEC_DW-1:0]          codec_data_out,
   input  logic                         codec_data_out_valid,
   input  logic                         controller_busy,
   input  logic                         missed_ack
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t              r_state, w_next;
   logic [PW-1:0]       r_ptr, w_idx;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_any, w_go, w_wait, w_tmo;
   logic                r_write, r_err;
   logic [CODEC_AW-1:0] r_addr;
   logic [CODEC_DW-1:0] r_wdata, r_rdata;
   logic [CW-1:0]       r_cnt;

   rr_arbiter #(.N(NUM_REQ), .W(PW)) u_rr (
      .i_req  (req_valid),
      .i_ptr  (r_ptr),
      .o_grant(w_grant),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // A busy controller (including codec init) holds off every grant.
   assign w_go   = (r_state == IDLE) && !controller_busy && w_any && !reset;
   assign w_wait = (r_state == WAIT_START) || (r_state == WAIT_DONE);
   // >= rather than == so a transaction that left WAIT_START on the timeout
   // cycle is still aborted on its first WAIT_DONE cycle.
   assign w_tmo  = w_wait && (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       w_next = w_go ? ISSUE : IDLE;
         ISSUE:      w_next = WAIT_START;
         WAIT_START: w_next = controller_busy ? WAIT_DONE : (w_tmo ? RESPOND : WAIT_START);
         WAIT_DONE:  w_next = (!controller_busy || w_tmo) ? RESPOND : WAIT_DONE;
         RESPOND:    w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ack     = w_go ? w_grant : '0;
      codec_wr_en = (r_state == ISSUE) && r_write;
      codec_rd_en = (r_state == ISSUE) && !r_write;
      rsp_valid   = (r_state == RESPOND) ? (NUM_REQ'(1) << r_ptr) : '0;
      rsp_rdata   = ((r_state == RESPOND) && !r_write) ? r_rdata : '0;
      rsp_error   = (r_state == RESPOND) && r_err;
      arb_busy    = r_state != IDLE;
   end

   assign codec_reg_addr = r_addr;
   assign codec_data_in  = r_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= PW'(NUM_REQ - 1);
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_go) begin
            r_ptr   <= w_idx;
            r_write <= req_write[w_idx];
            r_addr  <= req_addr[w_idx*CODEC_AW +: CODEC_AW];
            r_wdata <= req_wdata[w_idx*CODEC_DW +: CODEC_DW];
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
         if (r_state == ISSUE) r_cnt <= '0;
         else if (w_wait) r_cnt <= r_cnt + CW'(1);
         if (w_wait && codec_data_out_valid) r_rdata <= codec_data_out;
         if (w_wait && (missed_ack || w_tmo)) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_codec_reg_arbiter.sv
// tb_codec_reg_arbiter: directed self-checking bench for codec_reg_arbiter.
// Drives requesters and a hand-scripted controller; expected values are fixed
// per test (NUM_REQ=3, TIMEOUT_CYCLES=64).
module tb_codec_reg_arbiter;
   logic        clk = 0;
   logic        reset = 1;
   logic [2:0]  req_valid = 0, req_write = 0;
   logic [23:0] req_addr = 0;
   logic [26:0] req_wdata = 0;
   logic [2:0]  req_ack, rsp_valid;
   logic [8:0]  rsp_rdata, codec_data_in, codec_data_out = 0;
   logic        rsp_error, arb_busy, codec_rd_en, codec_wr_en;
   logic [7:0]  codec_reg_addr;
   logic        codec_data_out_valid = 0, controller_busy = 0, missed_ack = 0;
   int          errs = 0, checks = 0, nx = 0, strobes = 0, ovl = 0;

   codec_reg_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .arb_busy(arb_busy), .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
      .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
      .codec_data_out(codec_data_out), .codec_data_out_valid(codec_data_out_valid),
      .controller_busy(controller_busy), .missed_ack(missed_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (codec_rd_en && codec_wr_en) ovl++;
      if (codec_rd_en) strobes++;
      if (codec_wr_en) strobes++;
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(int r, bit wr, logic [7:0] a, logic [8:0] d);
      req_write[r] = wr;
      req_addr[r*8 +: 8] = a;
      req_wdata[r*9 +: 9] = d;
      req_valid[r] = 1'b1;
   endtask

   task automatic wait_ack(output int w);
      w = -1;
      #1;
      for (int n = 0; n < 50; n++) begin
         if (|req_ack) break;
         @(negedge clk);
         #1;
      end
      check("ack_seen", 32'(|req_ack), 1);
      check("ack_onehot", $countones(req_ack), 1);
      for (int i = 0; i < 3; i++) if (req_ack[i]) w = i;
   endtask

   // Runs one transaction from the ISSUE cycle to the idle cycle after RESPOND.
   task automatic ctrl(int blen, bit nack, bit dv, logic [8:0] rv, logic [2:0] drop,
                       bit wr, logic [7:0] a, logic [8:0] d, int r, logic [8:0] xr, bit xe);
      @(negedge clk);
      req_valid &= ~drop;
      if (drop != 0) begin
         req_addr = ~req_addr;
         req_wdata = ~req_wdata;
      end
      #1;
      check("wr_en", 32'(codec_wr_en), 32'(wr));
      check("rd_en", 32'(codec_rd_en), 32'(!wr));
      check("addr", 32'(codec_reg_addr), 32'(a));
      check("data_in", 32'(codec_data_in), 32'(d));
      nx++;
      for (int i = 0; i < blen; i++) begin
         @(negedge clk);
         controller_busy = 1;
         missed_ack = nack && (i == blen / 2);
      end
      @(negedge clk);
      controller_busy = 0;
      missed_ack = 0;
      codec_data_out_valid = dv;
      codec_data_out = rv;
      #1;
      check("rsp_early", 32'(rsp_valid), 0);
      @(negedge clk);
      codec_data_out_valid = 0;
      codec_data_out = 0;
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'(1) << r);
      check("rsp_rdata", 32'(rsp_rdata), 32'(xr));
      check("rsp_error", 32'(rsp_error), 32'(xe));
      @(negedge clk);
      #1;
      check("idle_busy", 32'(arb_busy), 0);
      check("idle_rsp", 32'(rsp_valid), 0);
   endtask

   initial begin
      int w, t, seen;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(arb_busy), 0);
      check("rst_strobe", 32'({codec_rd_en, codec_wr_en}), 0);
      check("rst_addr", 32'(codec_reg_addr), 0);
      check("rst_rsp", 32'(rsp_valid), 0);
      reset = 0;

      // single write from requester 1
      set_req(1, 1, 8'h07, 9'h1A5);
      wait_ack(w);
      check("w1_winner", w, 1);
      ctrl(20, 0, 0, 9'h000, 3'b010, 1, 8'h07, 9'h1A5, 1, 9'h000, 0);

      // read from requester 0, data valid on the busy-fall cycle
      set_req(0, 0, 8'h0F, 9'h000);
      wait_ack(w);
      check("rd_winner", w, 0);
      ctrl(5, 0, 1, 9'h0C3, 3'b001, 0, 8'h0F, 9'h000, 0, 9'h0C3, 0);

      // fairness: reset puts the pointer at 2, so order is 0,1,2,0,1,2
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 3; i++) set_req(i, 1, 8'h10 + 8'(i), 9'h100 + 9'(i));
      for (int k = 0; k < 6; k++) begin
         wait_ack(w);
         check("rr_order", w, k % 3);
         ctrl(2, 0, 0, 9'h000, (k == 5) ? 3'b111 : 3'b000, 1, 8'h10 + 8'(k % 3),
              9'h100 + 9'(k % 3), k % 3, 9'h000, 0);
      end

      // init hold-off
      controller_busy = 1;
      set_req(2, 0, 8'h22, 9'h000);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (|req_ack) seen++;
      end
      check("holdoff_acks", seen, 0);
      @(negedge clk);
      controller_busy = 0;
      #1;
      check("holdoff_ack", 32'(req_ack), 3'b100);
      ctrl(3, 0, 1, 9'h155, 3'b100, 0, 8'h22, 9'h000, 2, 9'h155, 0);

      // NACK mid-transaction
      set_req(1, 1, 8'h12, 9'h034);
      wait_ack(w);
      check("nack_winner", w, 1);
      ctrl(6, 1, 0, 9'h000, 3'b010, 1, 8'h12, 9'h034, 1, 9'h000, 1);

      // timeout: busy never rises; abort decided on the 64th wait cycle
      set_req(0, 0, 8'h30, 9'h000);
      wait_ack(w);
      check("tmo_winner", w, 0);
      @(negedge clk);
      req_valid = 0;
      #1;
      check("tmo_rd_en", 32'(codec_rd_en), 1);
      nx++;
      t = 0;
      while (t < 80 && !rsp_valid[0]) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("tmo_latency", t, 65);
      check("tmo_error", 32'(rsp_error), 1);
      check("tmo_rdata", 32'(rsp_rdata), 0);
      set_req(2, 1, 8'h44, 9'h0AA);
      wait_ack(w);
      check("post_tmo_winner", w, 2);
      ctrl(4, 0, 0, 9'h000, 3'b100, 1, 8'h44, 9'h0AA, 2, 9'h000, 0);

      // reset during WAIT_DONE
      set_req(1, 1, 8'h55, 9'h1FF);
      wait_ack(w);
      @(negedge clk);
      req_valid = 0;
      #1;
      check("rst_wr_en", 32'(codec_wr_en), 1);
      nx++;
      @(negedge clk);
      controller_busy = 1;
      @(negedge clk);
      #1;
      check("rst_pre_busy", 32'(arb_busy), 1);
      reset = 1;
      @(negedge clk);
      #1;
      check("rst_mid_ack", 32'(req_ack), 0);
      check("rst_mid_rsp", 32'({rsp_valid, rsp_rdata, rsp_error}), 0);
      check("rst_mid_busy", 32'(arb_busy), 0);
      check("rst_mid_strobe", 32'({codec_rd_en, codec_wr_en}), 0);
      check("rst_mid_addr", 32'(codec_reg_addr), 0);
      check("rst_mid_data", 32'(codec_data_in), 0);
      reset = 0;
      controller_busy = 0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (|rsp_valid) seen++;
      end
      check("rst_no_rsp", seen, 0);
      for (int i = 0; i < 3; i++) set_req(i, 1, 8'h61 + 8'(i), 9'h061 + 9'(i));
      wait_ack(w);
      check("rst_first_winner", w, 0);
      ctrl(2, 0, 0, 9'h000, 3'b111, 1, 8'h61, 9'h061, 0, 9'h000, 0);

      check("strobe_overlap", ovl, 0);
      check("strobe_count", strobes, nx);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
